// File: rtl/alu_muldiv_sequencer.sv
// Purpose : RV32M multiply/divide sequencer driving the shared EX-stage ALU one add/sub per cycle.
// Latency : accept -> rsp_valid in 35 cycles (2 cycles for divide-by-zero / signed overflow).
// Backpr. : holds DONE with rsp_data stable and stall high until rsp_ready; flush aborts any op.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/ready/op/a/b  request from EX (op = funct3)
//   flush                   abort in-flight op, no response
//   alu_own/a/b/sel         operands driven onto the shared ALU while iterating
//   alu_result              combinational ALU result for alu_a/alu_b/alu_sel
//   rsp_valid/data/ready    result handshake
//   stall                   freeze IF/ID/EX while an op is in flight
module alu_muldiv_sequencer #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   output logic        alu_own,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_sel,
   input  logic [31:0] alu_result,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   input  logic        rsp_ready,
   output logic        stall
);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   localparam logic [5:0] CNT_LOAD = 6'(ITERS - 1);
   localparam logic [3:0] SEL_ADD  = 4'b0000;
   localparam logic [3:0] SEL_SUB  = 4'b0001;

   state_t      r_state, w_next;
   logic [2:0]  r_op;
   logic        r_sa, r_sb;
   logic [31:0] r_a, r_b;        // |a| and |b|; r_b doubles as multiplicand / divisor
   logic [31:0] r_hi, r_lo;      // mul: product hi:lo, div: remainder:quotient
   logic [5:0]  r_cnt;
   logic [31:0] r_rsp;

   logic        w_accept;
   logic        w_sa, w_sb;
   logic        w_div_zero, w_div_ovf;
   logic [31:0] w_a_raw;
   logic [31:0] w_rs;
   logic        w_carry, w_sub_ok;
   logic [31:0] w_hi_neg;

   assign w_accept = (r_state == IDLE) && req_valid && !flush;

   // MULH, DIV, REM: both signed; MULHSU: only a signed.
   assign w_sa = req_a[31] && (req_op == 3'b001 || req_op == 3'b010 || req_op == 3'b100 || req_op == 3'b110);
   assign w_sb = req_b[31] && (req_op == 3'b001 || req_op == 3'b100 || req_op == 3'b110);

   assign w_div_zero = r_op[2] && (r_b == 32'd0);
   // Signed flags plus magnitudes uniquely identify a = INT_MIN, b = -1.
   assign w_div_ovf  = r_op[2] && !r_op[0] && r_sa && r_sb && (r_a == 32'h8000_0000) && (r_b == 32'd1);
   assign w_a_raw    = r_sa ? -r_a : r_a;

   // Divide step: shifted partial remainder; the bit shifted out makes it exceed any divisor.
   assign w_rs     = {r_hi[30:0], r_lo[31]};
   assign w_sub_ok = r_hi[31] || (w_rs >= r_b);
   assign w_carry  = alu_result < r_hi;
   // High word of the 64-bit two's complement negation: borrow only when the low word is zero.
   assign w_hi_neg = ~r_hi + {31'd0, (r_lo == 32'd0)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = PREP;
         PREP: if (flush) w_next = IDLE;
               else if (w_div_zero || w_div_ovf) w_next = DONE;
               else w_next = ITER;
         ITER: if (flush) w_next = IDLE;
               else if (r_cnt == 6'd0) w_next = FIX;
         FIX:  if (flush) w_next = IDLE;
               else w_next = DONE;
         DONE: if (flush || rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (r_state == IDLE);
      stall     = (r_state != IDLE) || w_accept;
      rsp_valid = (r_state == DONE);
      rsp_data  = (r_state == DONE) ? r_rsp : 32'd0;
      alu_own   = (r_state == ITER);
      alu_a     = 32'd0;
      alu_b     = 32'd0;
      alu_sel   = SEL_ADD;
      if (r_state == ITER) begin
         alu_b = r_b;
         if (r_op[2]) begin
            alu_a   = w_rs;
            alu_sel = SEL_SUB;
         end else begin
            alu_a = r_hi;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= 3'd0;
         r_sa  <= 1'b0;
         r_sb  <= 1'b0;
         r_a   <= 32'd0;
         r_b   <= 32'd0;
         r_hi  <= 32'd0;
         r_lo  <= 32'd0;
         r_cnt <= 6'd0;
         r_rsp <= 32'd0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_op <= req_op;
               r_sa <= w_sa;
               r_sb <= w_sb;
               r_a  <= w_sa ? -req_a : req_a;
               r_b  <= w_sb ? -req_b : req_b;
            end
            PREP: begin
               r_cnt <= CNT_LOAD;
               if (w_div_zero) begin
                  r_hi  <= w_a_raw;
                  r_lo  <= 32'hFFFF_FFFF;
                  r_rsp <= r_op[1] ? w_a_raw : 32'hFFFF_FFFF;
               end else if (w_div_ovf) begin
                  r_hi  <= 32'd0;
                  r_lo  <= 32'h8000_0000;
                  r_rsp <= r_op[1] ? 32'd0 : 32'h8000_0000;
               end else begin
                  r_hi <= 32'd0;
                  r_lo <= r_a;
               end
            end
            ITER: begin
               r_cnt <= r_cnt - 6'd1;
               if (r_op[2]) begin
                  r_hi <= w_sub_ok ? alu_result : w_rs;
                  r_lo <= {r_lo[30:0], w_sub_ok};
               end else if (r_lo[0]) begin
                  {r_hi, r_lo} <= {w_carry, alu_result, r_lo[31:1]};
               end else begin
                  {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
               end
            end
            FIX: begin
               // Sign flags are zero for unsigned ops and MUL, so one rule per group suffices.
               case (r_op)
                  3'b000:         r_rsp <= r_lo;
                  3'b001, 3'b010,
                  3'b011:         r_rsp <= (r_sa ^ r_sb) ? w_hi_neg : r_hi;
                  3'b100, 3'b101: r_rsp <= (r_sa ^ r_sb) ? -r_lo : r_lo;
                  default:        r_rsp <= r_sa ? -r_hi : r_hi;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
